// File: rtl/vlsu_r_credit_buffer.sv
// vlsu_r_credit_buffer: credit-based R-data buffer between the VLSU AXI cut
// (mst side) and the vector load unit (slv side).
//
// An AR is forwarded only once FIFO space for every beat of its burst is
// reserved, so R is never backpressured toward memory. The buffer absorbs
// vldu stalls, bounds bursts in flight and reports idle for load completion.
//
// Ports:
//   clk_i, rst_ni                   clock, synchronous active-low reset
//   slv_ar_i/_valid_i/_ready_o      AR from the address generator
//   mst_ar_o/_valid_o/_ready_i      AR toward the AXI cut (payload pass-through)
//   mst_r_i/_valid_i/_ready_o       R beats from the AXI cut
//   slv_r_o/_valid_o/_ready_i       buffered R beats to the vldu (FIFO head)
//   idle_o                          no reservations, no buffered beats, no bursts open

package vlsu_r_credit_buffer_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
  } ar_t;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } r_t;

endpackage

module vlsu_r_credit_buffer
  import vlsu_r_credit_buffer_pkg::*;
#(
  parameter int unsigned Depth         = 32,
  parameter int unsigned MaxBurstBeats = 16,
  parameter int unsigned MaxTxns       = 8,
  parameter type         axi_ar_t      = ar_t,
  parameter type         axi_r_t       = r_t
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  axi_ar_t slv_ar_i,
  input  logic    slv_ar_valid_i,
  output logic    slv_ar_ready_o,
  output axi_ar_t mst_ar_o,
  output logic    mst_ar_valid_o,
  input  logic    mst_ar_ready_i,
  input  axi_r_t  mst_r_i,
  input  logic    mst_r_valid_i,
  output logic    mst_r_ready_o,
  output axi_r_t  slv_r_o,
  output logic    slv_r_valid_o,
  input  logic    slv_r_ready_i,
  output logic    idle_o
);

  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam int unsigned TxnW = $clog2(MaxTxns + 1);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CmpW = (CntW > 9) ? CntW : 9;

  if (Depth < MaxBurstBeats) begin : g_depth_chk
    $error("vlsu_r_credit_buffer: Depth must be >= MaxBurstBeats");
  end

  logic [CntW-1:0] count_q, reserved_q;
  logic [TxnW-1:0] txns_q;
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  axi_r_t          mem_q [Depth];

  logic [CntW-1:0] free;
  logic [8:0]      ar_beats;
  logic            ok;
  logic            ar_fire, r_in, r_out, r_in_last;

  // Pointer increment modulo Depth (Depth need not be a power of two).
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Credit gate: space for the whole burst and a free transaction slot.
  always_comb begin
    free     = CntW'(Depth) - count_q - reserved_q;
    ar_beats = {1'b0, slv_ar_i.len} + 9'd1;
    ok       = rst_ni && (CmpW'(ar_beats) <= CmpW'(free)) && (txns_q < TxnW'(MaxTxns));
  end

  assign mst_ar_o       = slv_ar_i;
  assign mst_ar_valid_o = slv_ar_valid_i & ok;
  assign slv_ar_ready_o = mst_ar_ready_i & ok;

  // Space for every incoming beat was reserved at AR time.
  assign mst_r_ready_o  = rst_ni;

  assign slv_r_o        = mem_q[rd_ptr_q];
  assign slv_r_valid_o  = rst_ni & (count_q != '0);

  assign idle_o = ~rst_ni | ((count_q == '0) & (reserved_q == '0) & (txns_q == '0));

  assign ar_fire   = mst_ar_valid_o & mst_ar_ready_i;
  assign r_in      = mst_r_valid_i & mst_r_ready_o;
  assign r_in_last = r_in & mst_r_i.last;
  assign r_out     = slv_r_valid_o & slv_r_ready_i;

  // Counters and pointers; simultaneous events are net-summed.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q    <= '0;
      reserved_q <= '0;
      txns_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      count_q    <= count_q + CntW'(r_in) - CntW'(r_out);
      reserved_q <= reserved_q + (ar_fire ? CntW'(ar_beats) : '0) - CntW'(r_in);
      txns_q     <= txns_q + TxnW'(ar_fire) - TxnW'(r_in_last);
      if (r_in)  wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (r_out) rd_ptr_q <= ptr_inc(rd_ptr_q);
    end
  end

  // Beat storage; no reset needed, validity is tracked by count_q.
  always_ff @(posedge clk_i) begin
    if (r_in) mem_q[wr_ptr_q] <= mst_r_i;
  end

  a_burst_len: assert property (@(posedge clk_i) disable iff (!rst_ni)
    slv_ar_valid_i |-> (ar_beats <= 9'(MaxBurstBeats)));
  a_no_overcommit: assert property (@(posedge clk_i) disable iff (!rst_ni)
    ({1'b0, count_q} + {1'b0, reserved_q}) <= (CntW + 1)'(Depth));
  a_no_unsolicited: assert property (@(posedge clk_i) disable iff (!rst_ni)
    mst_r_valid_i |-> (reserved_q != '0));
  a_txn_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    r_in_last |-> (txns_q != '0));

endmodule

// File: tb/tb_vlsu_r_credit_buffer.sv
module tb_vlsu_r_credit_buffer;
  import vlsu_r_credit_buffer_pkg::*;

  localparam int DEPTH    = 32;
  localparam int MAX_TXNS = 8;
  localparam int BIG      = 1 << 30;

  logic clk = 1'b0;
  logic rst_n;
  ar_t  slv_ar, mst_ar;
  logic slv_ar_valid, slv_ar_ready, mst_ar_valid, mst_ar_ready;
  r_t   mst_r, slv_r;
  logic mst_r_valid, mst_r_ready, slv_r_valid, slv_r_ready;
  logic idle;

  vlsu_r_credit_buffer dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .slv_ar_i       (slv_ar),
    .slv_ar_valid_i (slv_ar_valid),
    .slv_ar_ready_o (slv_ar_ready),
    .mst_ar_o       (mst_ar),
    .mst_ar_valid_o (mst_ar_valid),
    .mst_ar_ready_i (mst_ar_ready),
    .mst_r_i        (mst_r),
    .mst_r_valid_i  (mst_r_valid),
    .mst_r_ready_o  (mst_r_ready),
    .slv_r_o        (slv_r),
    .slv_r_valid_o  (slv_r_valid),
    .slv_r_ready_i  (slv_r_ready),
    .idle_o         (idle)
  );

  always #5 clk = ~clk;

  // Reference model: totals of beats granted/received/drained and open bursts.
  int granted, recv, drained, open_b, seq, taken;
  r_t pend[$];   // beats memory still owes, in order
  r_t exp_q[$];  // beats accepted into the buffer, awaiting the vldu
  int r_limit, r_rate;
  int checks, errors;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard.
  initial begin
    granted = 0; recv = 0; drained = 0; open_b = 0; seq = 0; taken = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_mst_ar_valid", mst_ar_valid, 0);
        chk("rst_slv_ar_ready", slv_ar_ready, 0);
        chk("rst_mst_r_ready", mst_r_ready, 0);
        chk("rst_slv_r_valid", slv_r_valid, 0);
        chk("rst_idle", idle, 1);
        granted = 0; recv = 0; drained = 0; open_b = 0;
        pend.delete();
        exp_q.delete();
      end else begin
        int beats, outst;
        bit ok;
        r_t e, b;
        beats = int'(slv_ar.len) + 1;
        outst = granted - drained;
        ok    = (beats <= DEPTH - outst) && (open_b < MAX_TXNS);
        chk("mst_ar_valid", mst_ar_valid, slv_ar_valid && ok);
        chk("slv_ar_ready", slv_ar_ready, mst_ar_ready && ok);
        chk("mst_r_ready", mst_r_ready, 1);
        chk("slv_r_valid", slv_r_valid, (recv - drained) != 0);
        chk("idle", idle, (outst == 0) && (open_b == 0));
        if (slv_r_valid && slv_r_ready) begin
          if (exp_q.size() == 0) chk("r_out_unexpected", exp_q.size(), 1);
          else begin
            e = exp_q.pop_front();
            chk("r_out_data", slv_r.data, e.data);
            chk("r_out_last", slv_r.last, e.last);
          end
          drained++;
        end
        if (mst_r_valid && mst_r_ready) begin
          exp_q.push_back(mst_r);
          void'(pend.pop_front());
          recv++;
          taken++;
          if (mst_r.last) open_b--;
        end
        if (mst_ar_valid && mst_ar_ready) begin
          granted += beats;
          open_b++;
          for (int i = 0; i < beats; i++) begin
            b.data = 32'(seq);
            b.last = (i == beats - 1);
            seq++;
            pend.push_back(b);
          end
        end
      end
    end
  end

  // Memory-side R responder: returns owed beats in order, throttled by the driver.
  initial begin
    mst_r_valid = 1'b0;
    mst_r       = '0;
    forever begin
      @(posedge clk);
      #2;
      if (rst_n && pend.size() > 0 && taken < r_limit && $urandom_range(0, 99) < r_rate) begin
        mst_r_valid = 1'b1;
        mst_r       = pend[0];
      end else begin
        mst_r_valid = 1'b0;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_ar(input int len, input int bound, output int waited);
    slv_ar.len   = 8'(len);
    slv_ar.addr  = $urandom;
    slv_ar_valid = 1'b1;
    waited = 0;
    forever begin
      @(negedge clk);
      if (slv_ar_ready || waited >= bound) break;
      waited++;
    end
    chk("ar_grant_within_bound", slv_ar_ready, 1);
    @(posedge clk);
    #1;
    slv_ar_valid = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    for (int n = 0; n < bound; n++) begin
      @(negedge clk);
      if (idle) break;
    end
    chk("wait_idle", idle, 1);
    step(1);
  endtask

  task automatic wait_buffered(input int target, input int bound);
    for (int n = 0; n < bound; n++) begin
      @(negedge clk);
      if (recv - drained == target) break;
    end
    chk("wait_buffered", recv - drained, target);
    step(1);
  endtask

  // Stimulus driver.
  initial begin
    int w;
    bit fire;
    checks = 0; errors = 0;
    rst_n = 1'b0; slv_ar_valid = 1'b0; slv_ar = '0;
    mst_ar_ready = 1'b1; slv_r_ready = 1'b1;
    r_rate = 100; r_limit = BIG;
    step(3);
    rst_n = 1'b1;
    step(1);

    // Single len=3 burst, vldu always ready.
    send_ar(3, 20, w);
    chk("t1_ar_same_cycle", w, 0);
    wait_idle(50);

    // Two len=15 bursts fill the buffer; a third AR waits for one drain.
    slv_r_ready = 1'b0;
    send_ar(15, 20, w);
    chk("t2_ar1_wait", w, 0);
    send_ar(15, 20, w);
    chk("t2_ar2_wait", w, 0);
    wait_buffered(32, 100);
    r_limit = taken;
    slv_ar.len = 8'd0;
    slv_ar_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t2_third_ar_held", mst_ar_valid, 0);
    end
    step(1);
    slv_r_ready = 1'b1;
    step(1);
    slv_r_ready = 1'b0;
    @(negedge clk);
    chk("t2_third_ar_granted", mst_ar_valid, 1);
    step(1);
    slv_ar_valid = 1'b0;
    // Beat in and beat out in the same cycle at near-full occupancy.
    r_limit = taken + 1;
    slv_r_ready = 1'b1;
    @(negedge clk);
    chk("t2_in_out_same_cycle", mst_r_valid && slv_r_valid, 1);
    step(1);
    wait_idle(100);

    // Transaction limit: eight single-beat bursts with no R returned.
    r_limit = taken;
    for (int i = 0; i < 8; i++) begin
      send_ar(0, 20, w);
      chk("t3_ar_wait", w, 0);
    end
    slv_ar.len = 8'd0;
    slv_ar_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t3_ninth_ar_held", mst_ar_valid, 0);
    end
    step(1);
    r_limit = taken + 1;
    send_ar(0, 10, w);
    chk("t3_ninth_wait", w, 1);
    r_limit = BIG;
    wait_idle(100);

    // Reset with 5 beats buffered and 10 reserved.
    slv_r_ready = 1'b0;
    r_limit = taken + 5;
    send_ar(14, 20, w);
    wait_buffered(5, 100);
    step(3);
    chk("t5_pre_reset_buffered", recv - drained, 5);
    chk("t5_pre_reset_reserved", granted - recv, 10);
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    r_limit = BIG;
    slv_r_ready = 1'b1;
    @(negedge clk);
    chk("t5_post_reset_idle", idle, 1);
    chk("t5_post_reset_r_valid", slv_r_valid, 0);
    step(1);
    send_ar(0, 20, w);
    chk("t5_fresh_ar_wait", w, 0);
    wait_idle(50);

    // Randomized traffic with alternating vldu stall phases.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      fire = slv_ar_valid && slv_ar_ready;
      @(posedge clk);
      #1;
      slv_r_ready  = ((c / 400) % 2 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) != 0);
      mst_ar_ready = ($urandom_range(0, 3) != 0);
      if (c % 100 == 0) r_rate = $urandom_range(30, 100);
      if (!slv_ar_valid || fire) begin
        slv_ar_valid = ($urandom_range(0, 1) == 1);
        slv_ar.len   = ($urandom_range(0, 3) == 0) ? 8'd15 : 8'($urandom_range(0, 15));
        slv_ar.addr  = $urandom;
      end
    end
    slv_ar_valid = 1'b0;
    mst_ar_ready = 1'b1;
    slv_r_ready  = 1'b1;
    r_rate       = 100;
    wait_idle(2000);
    chk("end_scoreboard_empty", exp_q.size() + pend.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
